// File: rtl/pikarisc_pkg.sv
// Definitions shared between the PikaRISC instruction memory and its boot loader.
package pikarisc_pkg;

    localparam int IMEM_DEPTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } boot_state_e;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Word-stream input and instruction-memory test write port of the boot loader.
interface imem_boot_loader_if;

    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        imem_we;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_waddr, imem_wdata, imem_we
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_waddr, imem_wdata, imem_we
    );

endinterface

// File: rtl/loader_settle_cnt.sv
// Settle-delay down-counter: load sets the count, dec steps it toward zero and stops there.
module loader_settle_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/imem_boot_loader.sv
// Boot sequencer: streams words into instrMem, holds the core in reset while loading,
// then releases it after a fixed settle delay.
//
// state  | meaning
// IDLE   | after reset, waiting for load_start
// LOAD   | accepting words and writing them sequentially
// SETTLE | last write draining, core still held in reset
// RUN    | core released; load_start begins a reload
module imem_boot_loader
    import pikarisc_pkg::*;
#(
    parameter int DEPTH       = IMEM_DEPTH,
    parameter int AW          = $clog2(DEPTH),
    parameter int HOLD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_start,
    input  logic [AW:0]             load_len,
    imem_boot_loader_if.slave       bus,
    output logic                    core_reset,
    output logic                    busy,
    output logic                    done,
    output logic [AW:0]             words_loaded
);

    localparam int          CW      = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    boot_state_e   state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          core_reset_q, core_reset_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          in_ready;
    logic          accept;
    logic [AW:0]   start_len;
    logic          settle_load;
    logic          settle_zero;

    // Ready depends only on registered state so the source never sees a loop through in_valid.
    assign in_ready  = (state_q == ST_LOAD) && (cnt_q < len_q);
    assign accept    = bus.in_valid && in_ready;
    assign start_len = (load_len > DEPTH_W) ? DEPTH_W : load_len;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        settle_load = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                if (load_start) begin
                    len_d  = start_len;
                    cnt_d  = '0;
                    addr_d = '0;
                    if (start_len == '0) begin
                        state_d     = ST_SETTLE;
                        settle_load = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = 32'(addr_q);
                    wdata_d = bus.in_data;
                    addr_d  = addr_q + 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if ((cnt_q + 1'b1) == len_q) begin
                        state_d     = ST_SETTLE;
                        settle_load = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_zero) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        core_reset_d = (state_d == ST_RUN);
        done_d       = (state_d == ST_RUN);
        busy_d       = (state_d == ST_LOAD) || (state_d == ST_SETTLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            core_reset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Loaded on SETTLE entry; SETTLE therefore lasts HOLD_CYCLES + 1 cycles.
    loader_settle_cnt #(
        .W (CW)
    ) u_settle_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (settle_load),
        .load_val_i (CW'(HOLD_CYCLES)),
        .dec_i      (state_q == ST_SETTLE),
        .zero_o     (settle_zero)
    );

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign core_reset     = core_reset_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign words_loaded   = cnt_q;

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot sequencer for the PikaRISC instruction memory. It accepts a word stream over a valid/ready handshake and writes it sequentially into instrMem through the test write port. It holds the core in reset while loading, then releases it after a fixed settle delay. It replaces the fixed-length code-injection loop currently driven by the testbench, and the same logic also serves as a hardware loader.

## Interface
Parameters:
- DEPTH, 256: instruction memory depth in words; the maximum load length.
- AW, 8: word-address width; AW = clog2(DEPTH).
- HOLD_CYCLES, 2: number of cycles core_reset stays low after the last write.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- load_start  in  1  one-cycle pulse that begins a load; sampled in IDLE and RUN only.
- load_len  in  AW+1  number of words to load; sampled with load_start; values above DEPTH are clamped to DEPTH.
- in_valid  in  1  source word valid.
- in_data  in  32  source word.
- in_ready  out  1  loader accepts a word this cycle.
- imem_waddr  out  32  word address to the test_addr port; zero-extended from AW bits.
- imem_wdata  out  32  data to the test_data_in port.
- imem_we  out  1  write strobe, high for exactly one cycle per word.
- core_reset  out  1  active-low reset to PikaRISC.
- busy  out  1  high in LOAD and SETTLE.
- done  out  1  high in RUN.
- words_loaded  out  AW+1  count of words accepted in the current or last load.

## Operation
- States: IDLE, LOAD, SETTLE, RUN.
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_waddr 0, imem_wdata 0, core_reset 0, busy 0, done 0, words_loaded 0, settle counter 0.
- IDLE:
  - On load_start, latch len = min(load_len, DEPTH), clear words_loaded and the address counter, and go to LOAD.
  - If len = 0, go directly to SETTLE instead.
- LOAD:
  - in_ready = 1 while words_loaded < len.
  - Handshake: a word is accepted on a cycle where in_valid & in_ready.
  - On acceptance: imem_wdata <= in_data, imem_waddr <= address counter, imem_we <= 1 next cycle; then increment the address counter and words_loaded.
  - When the accepted word is number len, go to SETTLE. in_ready is 0 from that next cycle on.
  - in_valid without in_ready is ignored; the source must hold the word until it is accepted.
- SETTLE:
  - Counts HOLD_CYCLES cycles, then goes to RUN.
  - The final imem_we pulse is emitted during the first SETTLE cycle.
- RUN:
  - core_reset = 1, done = 1.
  - load_start returns to LOAD (or to SETTLE if len = 0). core_reset drops to 0 on the same edge that leaves RUN.
- core_reset is 0 in every state except RUN. It is a registered output: no combinational path from any input.
- load_start during LOAD or SETTLE is ignored.
- Address wrap: impossible, because len ≤ DEPTH. The counter never exceeds DEPTH-1 as a write address.
- Reset mid-operation: asynchronously returns every output to its reset value. Words already written to memory stay written; no write is ever issued for a partial word.

## Timing
- in_ready is a function of registered state only, with no dependence on in_valid.
- A word accepted at edge N appears on imem_we/imem_waddr/imem_wdata during the cycle after edge N and is written at edge N+1.
- Full throughput: one word per cycle while in_valid is held high. A len-word load with no stalls takes len cycles in LOAD.
- core_reset rises HOLD_CYCLES + 1 edges after the edge that accepts the last word; for len = 0, HOLD_CYCLES + 1 edges after load_start.
- done and core_reset change on the same edge.

## Structure
- Shared package (pikarisc_pkg): the state encoding (IDLE=0, LOAD=1, SETTLE=2, RUN=3) and the instruction-memory DEPTH constant shared with instrMem.
- One natural sub-module: loader_settle_cnt, a down-counter with load and zero flag. Everything else stays flat in one FSM module.

## Test plan
- Reset check: assert reset low mid-LOAD after 5 words -> all outputs are 0 immediately, state is IDLE, and no sixth write occurs.
- Basic load: load_start with load_len=44, stream 44 words with in_valid held high -> 44 consecutive imem_we pulses at addresses 0..43 with matching data, words_loaded=44, and core_reset rises 3 cycles after the last accept when HOLD_CYCLES=2.
- Back-pressure: toggle in_valid 1010… during a 4-word load -> exactly 4 writes, addresses 0..3, no duplicated or dropped word, in_ready stays high throughout LOAD.
- Boundaries:
  - load_len=0 -> no imem_we; done after HOLD_CYCLES+1 cycles.
  - load_len=300 with DEPTH=256 -> exactly 256 writes, last address 255.
- Reload: in RUN, pulse load_start with len=2 -> core_reset drops on the same edge, 2 words are written at addresses 0..1, then RUN is re-entered.
- Ignored start: pulse load_start during LOAD -> len and address are unchanged and the load completes normally.
